// File: rtl/if_axi_read_bridge_pkg.sv
// Shared AXI attribute/response codes, fetch-size encodings and bridge state
// encoding for the instruction-fetch AXI bridges.
package if_axi_read_bridge_pkg;

  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_PROT_IFETCH = 3'b100;
  localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] IF_SIZE_BYTE  = 2'b00;
  localparam logic [1:0] IF_SIZE_HALF  = 2'b01;
  localparam logic [1:0] IF_SIZE_WORD  = 2'b10;
  localparam logic [1:0] IF_SIZE_DWORD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // A request is naturally aligned when the low address bits below its size are zero.
  function automatic logic is_aligned(input logic [2:0] offset, input logic [1:0] size);
    logic ok;
    case (size)
      IF_SIZE_BYTE: ok = 1'b1;
      IF_SIZE_HALF: ok = (offset[0] == 1'b0);
      IF_SIZE_WORD: ok = (offset[1:0] == 2'b00);
      default:      ok = (offset == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/if_rdata_align.sv
// Extracts a 1/2/4/8-byte field from a 64-bit beat at the given byte offset,
// right-aligned and zero-extended.
module if_rdata_align
  import if_axi_read_bridge_pkg::*;
(
  input  logic [63:0] beat,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  output logic [63:0] data
);

  logic [63:0] shifted;

  assign shifted = beat >> {offset, 3'b000};

  always_comb begin
    data = 64'd0;
    case (size)
      IF_SIZE_BYTE: data = {56'd0, shifted[7:0]};
      IF_SIZE_HALF: data = {48'd0, shifted[15:0]};
      IF_SIZE_WORD: data = {32'd0, shifted[31:0]};
      default:      data = shifted;
    endcase
  end

endmodule

// File: rtl/if_axi_read_bridge.sv
// Instruction-fetch responder: turns one if_* fetch into a single-beat AXI4
// read and returns the size-aligned data with the AXI response code.
module if_axi_read_bridge
  import if_axi_read_bridge_pkg::*;
#(
  parameter int AXI_ID       = 0,
  parameter int AXI_ID_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_valid,
  input  logic [63:0]             if_addr,
  input  logic [1:0]              if_size,
  output logic                    if_ready,
  output logic [63:0]             if_data_read,
  output logic [1:0]              if_resp,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  output logic [63:0]             ar_addr,
  output logic [AXI_ID_WIDTH-1:0] ar_id,
  output logic [7:0]              ar_len,
  output logic [2:0]              ar_size,
  output logic [1:0]              ar_burst,
  output logic [2:0]              ar_prot,
  input  logic                    r_valid,
  output logic                    r_ready,
  input  logic [63:0]             r_data,
  input  logic [1:0]              r_resp,
  input  logic                    r_last,
  input  logic [AXI_ID_WIDTH-1:0] r_id
);

  logic [1:0]  state_reg;
  logic [63:0] addr_reg;
  logic [1:0]  size_reg;
  logic [63:0] data_reg;
  logic [1:0]  resp_reg;
  logic [63:0] aligned_data;

  // Single-beat, single-ID slave: last and ID carry no information here.
  logic unused_r_fields;
  assign unused_r_fields = r_last ^ (^r_id);

  if_rdata_align u_align (
    .beat   (r_data),
    .offset (addr_reg[2:0]),
    .size   (size_reg),
    .data   (aligned_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      addr_reg  <= 64'd0;
      size_reg  <= IF_SIZE_BYTE;
      data_reg  <= 64'd0;
      resp_reg  <= AXI_RESP_OKAY;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (if_valid) begin
            addr_reg <= if_addr;
            size_reg <= if_size;
            if (is_aligned(if_addr[2:0], if_size)) begin
              state_reg <= ST_ADDR;
            end else begin
              // Misaligned fetches are rejected locally without touching AXI.
              state_reg <= ST_DONE;
              data_reg  <= 64'd0;
              resp_reg  <= AXI_RESP_SLVERR;
            end
          end
        end
        ST_ADDR: begin
          if (ar_ready) state_reg <= ST_DATA;
        end
        ST_DATA: begin
          if (r_valid) begin
            data_reg  <= aligned_data;
            resp_reg  <= r_resp;
            state_reg <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign if_ready     = (state_reg == ST_DONE);
  assign ar_valid     = (state_reg == ST_ADDR);
  assign r_ready      = (state_reg == ST_DATA);
  assign if_data_read = data_reg;
  assign if_resp      = resp_reg;

  assign ar_addr  = {addr_reg[63:3], 3'b000};
  assign ar_id    = AXI_ID_WIDTH'(AXI_ID);
  assign ar_len   = AXI_LEN_SINGLE;
  assign ar_size  = AXI_SIZE_8B;
  assign ar_burst = AXI_BURST_INCR;
  assign ar_prot  = AXI_PROT_IFETCH;

endmodule

// File: tb/tb_if_axi_read_bridge.sv
// Bench for if_axi_read_bridge: directed and randomized fetches against a
// cycle-counted slave and a byte-level reference model.
module tb_if_axi_read_bridge;

  localparam int ID_W   = 4;
  localparam int TB_ID  = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            if_valid;
  logic [63:0]     if_addr;
  logic [1:0]      if_size;
  logic            if_ready;
  logic [63:0]     if_data_read;
  logic [1:0]      if_resp;
  logic            ar_valid;
  logic            ar_ready;
  logic [63:0]     ar_addr;
  logic [ID_W-1:0] ar_id;
  logic [7:0]      ar_len;
  logic [2:0]      ar_size;
  logic [1:0]      ar_burst;
  logic [2:0]      ar_prot;
  logic            r_valid;
  logic            r_ready;
  logic [63:0]     r_data;
  logic [1:0]      r_resp;
  logic            r_last;
  logic [ID_W-1:0] r_id;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  if_axi_read_bridge #(.AXI_ID(TB_ID), .AXI_ID_WIDTH(ID_W)) dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size),
    .if_ready(if_ready), .if_data_read(if_data_read), .if_resp(if_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_prot(ar_prot),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last), .r_id(r_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One fetch; entered at a negedge with the DUT idle. ard/rd are slave wait cycles.
  task automatic fetch(input logic [63:0] addr, input logic [1:0] size, input int ard,
                       input int rd, input logic [63:0] beat, input logic [1:0] resp,
                       input bit keep);
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
    bit          mis;
    int          off;
    int          done_cyc;
    mis      = (addr % (64'd1 << size)) != 64'd0;
    off      = int'(addr % 64'd8);
    exp_resp = mis ? 2'b10 : resp;
    exp_data = 64'd0;
    if (!mis)
      for (int b = 0; b < (1 << size); b++) exp_data[8*b +: 8] = beat[8*(off+b) +: 8];
    done_cyc = mis ? 1 : 3 + ard + rd;
    $display("fetch addr=%h size=%0d ar_wait=%0d r_wait=%0d resp=%0d exp_data=%h exp_resp=%0d",
             addr, size, ard, rd, resp, exp_data, exp_resp);
    if_valid = 1'b1; if_addr = addr; if_size = size;
    ar_ready = 1'b0; r_valid = 1'b0;
    for (int c = 1; c <= done_cyc; c++) begin
      step();
      if (c == done_cyc) begin
        chk("if_ready_done", if_ready, 1);
        chk("if_data_read", if_data_read, exp_data);
        chk("if_resp", if_resp, exp_resp);
        chk("ar_valid_done", ar_valid, 0);
        chk("r_ready_done", r_ready, 0);
      end else begin
        chk("if_ready_busy", if_ready, 0);
        if (c <= 1 + ard) begin
          chk("ar_valid_addr", ar_valid, 1);
          chk("ar_addr", ar_addr, addr & ~64'h7);
          chk("r_ready_addr", r_ready, 0);
        end else begin
          chk("r_ready_data", r_ready, 1);
          chk("ar_valid_data", ar_valid, 0);
        end
      end
      ar_ready = !mis && (c == 1 + ard);
      if (!mis && c == 2 + ard + rd) begin
        r_valid = 1'b1; r_data = beat; r_resp = resp;
      end else begin
        // Stray beats while the bridge is still in its address phase must be ignored.
        r_valid = (!mis && c <= 1 + ard) ? 1'($urandom) : 1'b0;
        r_data  = {$urandom, $urandom};
        r_resp  = 2'($urandom);
      end
      if (c < done_cyc) begin
        if_addr = {$urandom, $urandom};
        if_size = 2'($urandom);
      end
    end
    ar_ready = 1'b0; r_valid = 1'b0;
    if (keep) begin
      if_addr = addr + 64'd4; if_size = size;
    end else begin
      if_valid = 1'b0;
    end
    step();
    chk("if_ready_pulse", if_ready, 0);
    chk("ar_valid_idle", ar_valid, 0);
    chk("r_ready_idle", r_ready, 0);
    chk("data_held", if_data_read, exp_data);
    chk("resp_held", if_resp, exp_resp);
  endtask

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    bit          kp;
    reset = 1'b1; if_valid = 1'b0; if_addr = 64'd0; if_size = 2'd0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = 64'd0; r_resp = 2'd0;
    r_last = 1'b1; r_id = ID_W'(TB_ID);
    step(); step(); step();
    chk("rst_if_ready", if_ready, 0);
    chk("rst_if_data", if_data_read, 0);
    chk("rst_if_resp", if_resp, 0);
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_ar_addr", ar_addr, 0);
    chk("ar_id", ar_id, TB_ID);
    chk("ar_len", ar_len, 0);
    chk("ar_size", ar_size, 3);
    chk("ar_burst", ar_burst, 1);
    chk("ar_prot", ar_prot, 4);
    reset = 1'b0;
    step();

    fetch(64'h8000_0004, 2'b10, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 0);
    fetch(64'h8000_0010, 2'b11, 5, 3, 64'h0123_4567_89AB_CDEF, 2'b00, 0);
    fetch(64'h8000_0002, 2'b10, 0, 0, 64'h0, 2'b00, 0);
    fetch(64'h8000_0007, 2'b00, 1, 0, 64'hAB00_0000_0000_0000, 2'b11, 0);
    fetch(64'h8000_0006, 2'b01, 0, 2, 64'hBEEF_0000_0000_0000, 2'b01, 0);

    // Core holding if_valid and advancing pc by 4 on each completion.
    for (int i = 0; i < 4; i++)
      fetch(64'h8000_1000 + 64'(4 * i), 2'b10, i % 2, 0,
            {32'hC0DE_0000 + 32'(i), 32'hFACE_0000 + 32'(i)}, 2'b00, i < 3);

    // Randomized fetches, occasionally back-to-back.
    kp = 0; a = 64'd0; sz = 2'd0;
    for (int i = 0; i < 40; i++) begin
      if (kp) begin
        a = a + 64'd4;
      end else begin
        sz = 2'($urandom);
        a  = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      end
      kp = (i < 39) && ($urandom_range(0, 2) == 0);
      fetch(a, sz, $urandom_range(0, 3), $urandom_range(0, 3),
            {$urandom, $urandom}, 2'($urandom), kp);
    end

    // Reset while waiting for read data.
    $display("reset during DATA");
    if_valid = 1'b1; if_addr = 64'h8000_2000; if_size = 2'b11;
    step();
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    chk("pre_rst_r_ready", r_ready, 1);
    reset = 1'b1; if_valid = 1'b0; r_valid = 1'b1; r_data = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    chk("mid_rst_r_ready", r_ready, 0);
    chk("mid_rst_ar_valid", ar_valid, 0);
    chk("mid_rst_if_ready", if_ready, 0);
    chk("mid_rst_if_data", if_data_read, 0);
    chk("mid_rst_ar_addr", ar_addr, 0);
    reset = 1'b0; r_valid = 1'b0;
    step();
    chk("post_rst_if_ready", if_ready, 0);
    fetch(64'h8000_3008, 2'b11, 1, 1, 64'h5A5A_A5A5_1234_5678, 2'b00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
